voq_xbar_sched: RTL

Parametrised round-robin crossbar scheduler for the N×N VOQ switch: once per scheduling epoch it picks, for every ingress port, at most one egress, so that no egress is granted twice. Busy ingress ports that are mid-packet keep their current egress unconditionally. It sits between the ingress VOQ blocks (which report `voq_empty` and the busy state) and the ingress dequeue logic (which consumes `sched_sel_en`/`sched_sel`). It is the N-port successor of the 4-port scheduler, adding reset, input snapshotting, a completion strobe, a fixed-priority mode and a true round-robin egress pointer.

---
 rtl/voq_sched_pkg.sv | 21 ++
 rtl/voq_xbar_sched_if.sv | 27 ++
 rtl/rr_first_avail.sv | 33 +++
 rtl/voq_xbar_sched.sv | 133 +++++++++++++
 4 files changed

// File: rtl/voq_sched_pkg.sv
// Shared types and constants for the VOQ crossbar scheduler.
//   port_idx_t    : port index type for the default 4-port build
//   sched_state_e : scheduler FSM states
//   SCHED_FIXED / SCHED_RR : values of rr_mode
package voq_sched_pkg;

  localparam int unsigned N_PORT_DEF = 4;
  localparam int unsigned PTR_W_DEF  = $clog2(N_PORT_DEF);

  typedef logic [PTR_W_DEF-1:0] port_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSIGN = 2'd1,
    ST_COMMIT = 2'd2
  } sched_state_e;

  localparam logic SCHED_FIXED = 1'b0;
  localparam logic SCHED_RR    = 1'b1;

endpackage

// File: rtl/voq_xbar_sched_if.sv
// Request/result bundle between the VOQ ingress blocks and the scheduler.
//   master : ingress side (drives requests, consumes results)
//   slave  : scheduler side
interface voq_xbar_sched_if #(
  parameter int unsigned N_PORT = 4,
  parameter int unsigned PTR_W  = $clog2(N_PORT)
);
  logic                       rr_mode;
  logic                       sched_en;
  logic [N_PORT-1:0]          is_busy;
  logic [N_PORT*PTR_W-1:0]    busy_voq_num;
  logic [N_PORT*N_PORT-1:0]   voq_empty;
  logic [N_PORT-1:0]          sched_sel_en;
  logic [N_PORT*PTR_W-1:0]    sched_sel;
  logic                       sched_done;
  logic                       sched_active;

  modport master (
    output rr_mode, sched_en, is_busy, busy_voq_num, voq_empty,
    input  sched_sel_en, sched_sel, sched_done, sched_active
  );

  modport slave (
    input  rr_mode, sched_en, is_busy, busy_voq_num, voq_empty,
    output sched_sel_en, sched_sel, sched_done, sched_active
  );
endinterface

// File: rtl/rr_first_avail.sv
// Rotating priority encoder: first set bit of i_req at or after i_start,
// wrapping modulo N_PORT.
//   i_req      : request vector
//   i_start    : index where the search begins
//   o_found_c  : some request was found
//   o_idx_c    : index of the first request found (0 when none)
module rr_first_avail #(
  parameter int unsigned N_PORT = 4,
  parameter int unsigned PTR_W  = $clog2(N_PORT)
) (
  input  logic [N_PORT-1:0] i_req,
  input  logic [PTR_W-1:0]  i_start,
  output logic              o_found_c,
  output logic [PTR_W-1:0]  o_idx_c
);

  logic [PTR_W-1:0] w_idx;

  // Power-of-two N_PORT lets the PTR_W-bit add wrap for free.
  always_comb begin
    o_found_c = 1'b0;
    o_idx_c   = '0;
    w_idx     = '0;
    for (int k = 0; k < N_PORT; k++) begin
      w_idx = i_start + PTR_W'(k);
      if (!o_found_c && i_req[w_idx]) begin
        o_found_c = 1'b1;
        o_idx_c   = w_idx;
      end
    end
  end

endmodule

// File: rtl/voq_xbar_sched.sv
// N-port round-robin / fixed-priority crossbar scheduler. Per epoch it
// assigns at most one egress to each ingress with no egress granted twice;
// busy ingresses keep their current egress.
//   clk, reset : clock, synchronous active-high reset
//   sched_if   : slave side of voq_xbar_sched_if (requests in, grants out)
module voq_xbar_sched
  import voq_sched_pkg::*;
#(
  parameter int unsigned N_PORT = 4
) (
  input logic              clk,
  input logic              reset,
  voq_xbar_sched_if.slave  sched_if
);

  localparam int unsigned PTR_W = $clog2(N_PORT);
  localparam int unsigned LAST  = N_PORT - 1;

  sched_state_e            r_state;
  logic [PTR_W-1:0]        r_step, r_cur, r_start;
  logic [PTR_W-1:0]        r_ptr      [N_PORT];
  logic [PTR_W-1:0]        r_busy_num [N_PORT];
  logic [PTR_W-1:0]        r_wsel     [N_PORT];
  logic [N_PORT-1:0]       r_empty    [N_PORT];
  logic [N_PORT-1:0]       r_taken, r_busy, r_wen, r_sel_en;
  logic [N_PORT*PTR_W-1:0] r_sel;
  logic                    r_rr, r_done, r_active;

  logic [N_PORT-1:0]       w_taken_init, w_req;
  logic [PTR_W-1:0]        w_search_start, w_hit_idx;
  logic                    w_hit, w_busy_conflict;

  // Egresses held by busy ports are reserved before any search runs.
  always_comb begin
    w_taken_init    = '0;
    w_busy_conflict = 1'b0;
    for (int i = 0; i < N_PORT; i++) begin
      if (sched_if.is_busy[i]) begin
        if (w_taken_init[sched_if.busy_voq_num[i*PTR_W +: PTR_W]])
          w_busy_conflict = 1'b1;
        w_taken_init[sched_if.busy_voq_num[i*PTR_W +: PTR_W]] = 1'b1;
      end
    end
  end

  assign w_req          = ~r_empty[r_cur] & ~r_taken;
  assign w_search_start = (r_rr == SCHED_RR) ? r_ptr[r_cur] : '0;

  rr_first_avail #(.N_PORT(N_PORT), .PTR_W(PTR_W)) u_first_avail (
    .i_req     (w_req),
    .i_start   (w_search_start),
    .o_found_c (w_hit),
    .o_idx_c   (w_hit_idx)
  );

  // Scheduler FSM: snapshot in IDLE, one ingress per ASSIGN cycle, publish in COMMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_step   <= '0;
      r_cur    <= '0;
      r_start  <= '0;
      r_taken  <= '0;
      r_busy   <= '0;
      r_wen    <= '0;
      r_sel_en <= '0;
      r_sel    <= '0;
      r_rr     <= 1'b0;
      r_done   <= 1'b0;
      r_active <= 1'b0;
      for (int i = 0; i < N_PORT; i++) begin
        r_ptr[i]      <= '0;
        r_busy_num[i] <= '0;
        r_wsel[i]     <= '0;
        r_empty[i]    <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (sched_if.sched_en) begin
            // Two busy ports on one egress is an upstream protocol violation.
            assert (!w_busy_conflict);
            r_busy   <= sched_if.is_busy;
            r_rr     <= sched_if.rr_mode;
            for (int i = 0; i < N_PORT; i++) begin
              r_busy_num[i] <= sched_if.busy_voq_num[i*PTR_W +: PTR_W];
              r_empty[i]    <= sched_if.voq_empty[i*N_PORT +: N_PORT];
            end
            r_sel_en <= '0;
            r_step   <= '0;
            r_cur    <= (sched_if.rr_mode == SCHED_RR) ? r_start : '0;
            r_taken  <= w_taken_init;
            r_active <= 1'b1;
            r_state  <= ST_ASSIGN;
          end
        end
        ST_ASSIGN: begin
          if (r_busy[r_cur]) begin
            r_wen[r_cur]  <= 1'b1;
            r_wsel[r_cur] <= r_busy_num[r_cur];
          end else if (w_hit) begin
            r_taken[w_hit_idx] <= 1'b1;
            r_wen[r_cur]       <= 1'b1;
            r_wsel[r_cur]      <= w_hit_idx;
            if (r_rr == SCHED_RR) r_ptr[r_cur] <= w_hit_idx + PTR_W'(1);
          end else begin
            r_wen[r_cur]  <= 1'b0;
            r_wsel[r_cur] <= '0;
          end
          r_cur  <= r_cur + PTR_W'(1);
          r_step <= r_step + PTR_W'(1);
          if (r_step == PTR_W'(LAST)) r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          r_sel_en <= r_wen;
          for (int i = 0; i < N_PORT; i++) r_sel[i*PTR_W +: PTR_W] <= r_wsel[i];
          r_done   <= 1'b1;
          r_active <= 1'b0;
          if (r_rr == SCHED_RR) r_start <= r_start + PTR_W'(1);
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sched_if.sched_sel_en = r_sel_en;
  assign sched_if.sched_sel    = r_sel;
  assign sched_if.sched_done   = r_done;
  assign sched_if.sched_active = r_active;

endmodule
